// File: rtl/mmu_resp_pkg.sv
// Shared types and constants for the mmu_resp memory-side responder.
package mmu_resp_pkg;

    localparam int DEF_ADDR_W = 32;
    localparam int DEF_DATA_W = 32;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_REQ  = 1'b1
    } state_t;

    // Slot indices double as bit positions in the pending vector.
    localparam logic [1:0] SLOT_I = 2'd0;
    localparam logic [1:0] SLOT_D = 2'd1;
    localparam logic [1:0] SLOT_W = 2'd2;

    function automatic logic [2:0] slot_mask(input logic [1:0] slot);
        return 3'b001 << slot;
    endfunction

endpackage

// File: rtl/mmu_resp_arb.sv
// Grant selection for mmu_resp: W first, then D/I (fixed D>I, or alternating
// D/I when MMU_RESP_ROUND_ROBIN_EN is defined).
module mmu_resp_arb
    import mmu_resp_pkg::*;
(
`ifdef MMU_RESP_ROUND_ROBIN_EN
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rd_ack,
    input  logic [1:0] ack_slot,
`endif
    input  logic [2:0] pend,
    output logic       gnt_valid,
    output logic [1:0] gnt_slot
);

    logic prefer_i;

`ifdef MMU_RESP_ROUND_ROBIN_EN
    // Set when D was the last read served, so I wins the next D/I tie.
    logic last_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_d <= 1'b0;
        end else if (rd_ack) begin
            last_d <= (ack_slot == SLOT_D);
        end
    end

    assign prefer_i = last_d;
`else
    assign prefer_i = 1'b0;
`endif

    always_comb begin
        gnt_valid = |pend;
        gnt_slot  = SLOT_I;
        if (pend[SLOT_W]) begin
            gnt_slot = SLOT_W;
        end else if (pend[SLOT_D] && pend[SLOT_I]) begin
            gnt_slot = prefer_i ? SLOT_I : SLOT_D;
        end else if (pend[SLOT_D]) begin
            gnt_slot = SLOT_D;
        end
    end

endmodule

// File: rtl/mmu_resp.sv
// Memory-side responder: captures I/D/W requests and serialises them onto one
// req/ack backend port. Optional feature macro: MMU_RESP_ROUND_ROBIN_EN.
module mmu_resp
    import mmu_resp_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              INST_RDEN,
    input  logic [ADDR_W-1:0] INST_RIADDR,
    output logic [ADDR_W-1:0] INST_ROADDR,
    output logic              INST_RVALID,
    output logic [DATA_W-1:0] INST_RDATA,
    input  logic              DATA_RDEN,
    input  logic [ADDR_W-1:0] DATA_RIADDR,
    output logic [ADDR_W-1:0] DATA_ROADDR,
    output logic              DATA_RVALID,
    output logic [DATA_W-1:0] DATA_RDATA,
    input  logic              DATA_WREN,
    input  logic [ADDR_W-1:0] DATA_WADDR,
    input  logic [DATA_W-1:0] DATA_WDATA,
    output logic              MEM_WAIT,
    output logic              MEM_REQ,
    output logic              MEM_WE,
    output logic [ADDR_W-1:0] MEM_ADDR,
    output logic [DATA_W-1:0] MEM_WDATA,
    input  logic              MEM_ACK,
    input  logic [DATA_W-1:0] MEM_RDATA
);

    state_t            state;
    state_t            state_next;
    logic [2:0]        pend;
    logic [ADDR_W-1:0] i_addr;
    logic [ADDR_W-1:0] d_addr;
    logic [ADDR_W-1:0] w_addr;
    logic [DATA_W-1:0] w_data;
    logic [1:0]        cur_slot;
    logic [2:0]        arb_pend;
    logic              gnt_valid;
    logic [1:0]        gnt_slot;
    logic              load;
    logic              done;

    assign MEM_WAIT = |pend;
    assign MEM_REQ  = (state == ST_REQ);

    // The slot being acked this cycle must not be re-granted back-to-back.
    assign arb_pend = pend & ~((state == ST_REQ) ? slot_mask(cur_slot) : 3'b000);

    mmu_resp_arb u_arb (
`ifdef MMU_RESP_ROUND_ROBIN_EN
        .clk       (CLK),
        .rst_n     (RST),
        .rd_ack    (done && (cur_slot != SLOT_W)),
        .ack_slot  (cur_slot),
`endif
        .pend      (arb_pend),
        .gnt_valid (gnt_valid),
        .gnt_slot  (gnt_slot)
    );

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        load       = 1'b0;
        done       = 1'b0;
        case (state)
            ST_IDLE: begin
                if (gnt_valid) begin
                    load       = 1'b1;
                    state_next = ST_REQ;
                end
            end
            ST_REQ: begin
                if (MEM_ACK) begin
                    done = 1'b1;
                    if (gnt_valid) begin
                        load = 1'b1;
                    end else begin
                        state_next = ST_IDLE;
                    end
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // MEM_WAIT low implies all slots empty and IDLE, so capture and clear never collide.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            pend   <= 3'b000;
            i_addr <= '0;
            d_addr <= '0;
            w_addr <= '0;
            w_data <= '0;
        end else if (!MEM_WAIT) begin
            pend <= {DATA_WREN, DATA_RDEN, INST_RDEN};
            if (INST_RDEN) i_addr <= INST_RIADDR;
            if (DATA_RDEN) d_addr <= DATA_RIADDR;
            if (DATA_WREN) begin
                w_addr <= DATA_WADDR;
                w_data <= DATA_WDATA;
            end
        end else if (done) begin
            pend <= pend & ~slot_mask(cur_slot);
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            cur_slot  <= SLOT_I;
            MEM_WE    <= 1'b0;
            MEM_ADDR  <= '0;
            MEM_WDATA <= '0;
        end else if (load) begin
            cur_slot <= gnt_slot;
            MEM_WE   <= (gnt_slot == SLOT_W);
            case (gnt_slot)
                SLOT_W:  MEM_ADDR <= w_addr;
                SLOT_D:  MEM_ADDR <= d_addr;
                default: MEM_ADDR <= i_addr;
            endcase
            MEM_WDATA <= (gnt_slot == SLOT_W) ? w_data : '0;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            INST_RVALID <= 1'b0;
            INST_ROADDR <= '0;
            INST_RDATA  <= '0;
            DATA_RVALID <= 1'b0;
            DATA_ROADDR <= '0;
            DATA_RDATA  <= '0;
        end else begin
            INST_RVALID <= 1'b0;
            DATA_RVALID <= 1'b0;
            if (done && (cur_slot == SLOT_I)) begin
                INST_RVALID <= 1'b1;
                INST_ROADDR <= i_addr;
                INST_RDATA  <= MEM_RDATA;
            end
            if (done && (cur_slot == SLOT_D)) begin
                DATA_RVALID <= 1'b1;
                DATA_ROADDR <= d_addr;
                DATA_RDATA  <= MEM_RDATA;
            end
        end
    end

endmodule

// File: tb/tb_mmu_resp.sv
// Randomised self-checking bench for mmu_resp; a cycle schedule is derived
// per request batch from the priority and timing rules and compared each cycle.
module tb_mmu_resp;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        INST_RDEN = 1'b0;
    logic [31:0] INST_RIADDR = '0;
    logic [31:0] INST_ROADDR;
    logic        INST_RVALID;
    logic [31:0] INST_RDATA;
    logic        DATA_RDEN = 1'b0;
    logic [31:0] DATA_RIADDR = '0;
    logic [31:0] DATA_ROADDR;
    logic        DATA_RVALID;
    logic [31:0] DATA_RDATA;
    logic        DATA_WREN = 1'b0;
    logic [31:0] DATA_WADDR = '0;
    logic [31:0] DATA_WDATA = '0;
    logic        MEM_WAIT;
    logic        MEM_REQ;
    logic        MEM_WE;
    logic [31:0] MEM_ADDR;
    logic [31:0] MEM_WDATA;
    logic        MEM_ACK = 1'b0;
    logic [31:0] MEM_RDATA = '0;

    mmu_resp dut (
        .CLK         (CLK),
        .RST         (RST),
        .INST_RDEN   (INST_RDEN),
        .INST_RIADDR (INST_RIADDR),
        .INST_ROADDR (INST_ROADDR),
        .INST_RVALID (INST_RVALID),
        .INST_RDATA  (INST_RDATA),
        .DATA_RDEN   (DATA_RDEN),
        .DATA_RIADDR (DATA_RIADDR),
        .DATA_ROADDR (DATA_ROADDR),
        .DATA_RVALID (DATA_RVALID),
        .DATA_RDATA  (DATA_RDATA),
        .DATA_WREN   (DATA_WREN),
        .DATA_WADDR  (DATA_WADDR),
        .DATA_WDATA  (DATA_WDATA),
        .MEM_WAIT    (MEM_WAIT),
        .MEM_REQ     (MEM_REQ),
        .MEM_WE      (MEM_WE),
        .MEM_ADDR    (MEM_ADDR),
        .MEM_WDATA   (MEM_WDATA),
        .MEM_ACK     (MEM_ACK),
        .MEM_RDATA   (MEM_RDATA)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        bit        we;
        bit        is_i;
        bit [31:0] addr;
        bit [31:0] data;
        int        wt;
    } txn_t;

    int n_checks = 0;
    int n_fail   = 0;

    bit [31:0] ref_mem[bit [31:0]];
    bit [31:0] dev_mem[bit [31:0]];

    // Expected held response values and the response due at the next sample.
    bit [31:0] exp_i_addr = '0, exp_i_data = '0, exp_d_addr = '0, exp_d_data = '0;
    bit        due_i = 1'b0, due_d = 1'b0;
    bit [31:0] due_addr = '0, due_data = '0;
    bit        rr_last_d = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic bit [31:0] mem_init(input bit [31:0] a);
        return (a * 32'd2654435761) ^ 32'h5A5A_0000;
    endfunction

    function automatic bit [31:0] ref_rd(input bit [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : mem_init(a);
    endfunction

    function automatic bit [31:0] dev_rd(input bit [31:0] a);
        return dev_mem.exists(a) ? dev_mem[a] : mem_init(a);
    endfunction

    task automatic check_rsp();
        if (due_i) begin
            exp_i_addr = due_addr;
            exp_i_data = due_data;
        end
        if (due_d) begin
            exp_d_addr = due_addr;
            exp_d_data = due_data;
        end
        check_eq("inst_rvalid", INST_RVALID, due_i);
        check_eq("data_rvalid", DATA_RVALID, due_d);
        check_eq("inst_roaddr", INST_ROADDR, exp_i_addr);
        check_eq("inst_rdata", INST_RDATA, exp_i_data);
        check_eq("data_roaddr", DATA_ROADDR, exp_d_addr);
        check_eq("data_rdata", DATA_RDATA, exp_d_data);
        due_i = 1'b0;
        due_d = 1'b0;
    endtask

    task automatic drive_garbage();
        INST_RDEN   = 1'($urandom);
        INST_RIADDR = 32'h300;
        DATA_RDEN   = 1'($urandom);
        DATA_RIADDR = $urandom;
        DATA_WREN   = 1'($urandom);
        DATA_WADDR  = $urandom;
        DATA_WDATA  = $urandom;
    endtask

    // Entered and left at the negedge of a cycle in which the DUT should be idle.
    task automatic run_batch(input bit ien, input bit [31:0] ia, input bit den, input bit [31:0] da,
                             input bit wen, input bit [31:0] wa, input bit [31:0] wd, input int fw);
        txn_t q[$];
        txn_t t;
        bit   d_first;
        check_eq("idle_wait", MEM_WAIT, 1'b0);
        check_eq("idle_req", MEM_REQ, 1'b0);
        check_rsp();
        INST_RDEN = ien; INST_RIADDR = ia;
        DATA_RDEN = den; DATA_RIADDR = da;
        DATA_WREN = wen; DATA_WADDR = wa; DATA_WDATA = wd;
        MEM_ACK   = 1'($urandom);
        if (wen) begin
            ref_mem[wa] = wd;
            q.push_back('{we: 1'b1, is_i: 1'b0, addr: wa, data: wd, wt: 0});
        end
`ifdef MMU_RESP_ROUND_ROBIN_EN
        d_first = !rr_last_d;
`else
        d_first = 1'b1;
`endif
        if (den && (d_first || !ien)) q.push_back('{we: 1'b0, is_i: 1'b0, addr: da, data: ref_rd(da), wt: 0});
        if (ien) q.push_back('{we: 1'b0, is_i: 1'b1, addr: ia, data: ref_rd(ia), wt: 0});
        if (den && !d_first && ien) q.push_back('{we: 1'b0, is_i: 1'b0, addr: da, data: ref_rd(da), wt: 0});
        foreach (q[n]) q[n].wt = (fw >= 0) ? fw : int'($urandom_range(0, 3));

        @(negedge CLK);
        if (q.size() == 0) begin
            MEM_ACK = 1'b0;
            INST_RDEN = 1'b0; DATA_RDEN = 1'b0; DATA_WREN = 1'b0;
            return;
        end
        check_eq("grant_wait", MEM_WAIT, 1'b1);
        check_eq("grant_req", MEM_REQ, 1'b0);
        check_rsp();
        drive_garbage();
        MEM_ACK = 1'($urandom);

        while (q.size() > 0) begin
            t = q.pop_front();
            for (int k = 0; k <= t.wt; k++) begin
                @(negedge CLK);
                check_eq("req", MEM_REQ, 1'b1);
                check_eq("busy_wait", MEM_WAIT, 1'b1);
                check_eq("mem_addr", MEM_ADDR, t.addr);
                check_eq("mem_we", MEM_WE, t.we);
                if (t.we) check_eq("mem_wdata", MEM_WDATA, t.data);
                check_rsp();
                drive_garbage();
                MEM_ACK   = (k == t.wt);
                MEM_RDATA = dev_rd(MEM_ADDR);
                if (k == t.wt) begin
                    if (MEM_WE) dev_mem[MEM_ADDR] = MEM_WDATA;
                    if (!t.we) begin
                        due_i     = t.is_i;
                        due_d     = !t.is_i;
                        due_addr  = t.addr;
                        due_data  = t.data;
                        rr_last_d = !t.is_i;
                    end
                    $display("txn %s addr=0x%08h data=0x%08h wait=%0d",
                             t.we ? "W" : (t.is_i ? "I" : "D"), t.addr, t.data, t.wt);
                end
            end
        end
        @(negedge CLK);
        MEM_ACK = 1'b0;
        INST_RDEN = 1'b0; DATA_RDEN = 1'b0; DATA_WREN = 1'b0;
    endtask

    task automatic random_batches(input int n);
        for (int b = 0; b < n; b++) begin
            run_batch(1'($urandom), 32'h100 + 32'($urandom_range(0, 7)) * 4,
                      1'($urandom), 32'h200 + 32'($urandom_range(0, 7)) * 4,
                      1'($urandom), 32'h200 + 32'($urandom_range(0, 7)) * 4,
                      $urandom, -1);
        end
    endtask

    initial begin
        #1;
        check_eq("rst_wait", MEM_WAIT, 1'b0);
        check_eq("rst_req", MEM_REQ, 1'b0);
        check_eq("rst_we", MEM_WE, 1'b0);
        check_eq("rst_addr", MEM_ADDR, 32'h0);
        check_eq("rst_ivalid", INST_RVALID, 1'b0);
        check_eq("rst_dvalid", DATA_RVALID, 1'b0);
        repeat (2) @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);

        ref_mem[32'h100] = 32'h0000_0013;
        dev_mem[32'h100] = 32'h0000_0013;
        run_batch(1'b1, 32'h100, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 0);
        run_batch(1'b1, 32'h104, 1'b1, 32'h200, 1'b1, 32'h200, 32'hDEADBEEF, 0);
        run_batch(1'b0, 32'h0, 1'b1, 32'h204, 1'b0, 32'h0, 32'h0, 3);
        for (int r = 0; r < 4; r++) run_batch(1'b1, 32'h108, 1'b1, 32'h208, 1'b0, 32'h0, 32'h0, 0);
        random_batches(60);

        // Abort an instruction read in REQ; the late ack must be ignored.
        check_rsp();
        INST_RDEN = 1'b1; INST_RIADDR = 32'h180;
        @(negedge CLK);
        INST_RDEN = 1'b0;
        check_eq("abort_wait", MEM_WAIT, 1'b1);
        @(negedge CLK);
        check_eq("abort_req_on", MEM_REQ, 1'b1);
        RST = 1'b0;
        #1;
        check_eq("abort_req_off", MEM_REQ, 1'b0);
        check_eq("abort_wait_off", MEM_WAIT, 1'b0);
        @(negedge CLK);
        RST = 1'b1;
        MEM_ACK = 1'b1;
        @(negedge CLK);
        MEM_ACK = 1'b0;
        exp_i_addr = '0; exp_i_data = '0; exp_d_addr = '0; exp_d_data = '0;
        rr_last_d = 1'b0;
        check_eq("abort_req_after", MEM_REQ, 1'b0);
        check_rsp();
        @(negedge CLK);
        check_eq("abort_slots_empty", MEM_WAIT, 1'b0);
        check_rsp();

        random_batches(30);
        check_rsp();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mmu_resp.md
# mmu_resp

Memory-side responder for the core's instruction-read, data-read and data-write request ports. It captures up to one request per port and serialises them onto a single backend memory port using a req/ack handshake. It returns read data tagged with the request address, and drives the core's global `MEM_WAIT` stall. It sits between the core and the memory/bus bridge.

## Interface
Parameters:
- `ADDR_W`, 32: address width on both sides.
- `DATA_W`, 32: data width on both sides.

Ports:
- `CLK`  in  1  sole clock.
- `RST`  in  1  asynchronous, active-low reset.
- `INST_RDEN`  in  1  instruction read request.
- `INST_RIADDR`  in  ADDR_W  instruction read address.
- `INST_ROADDR`  out  ADDR_W  address of the returned instruction.
- `INST_RVALID`  out  1  one-cycle pulse: instruction data valid.
- `INST_RDATA`  out  DATA_W  instruction data.
- `DATA_RDEN`  in  1  data read request.
- `DATA_RIADDR`  in  ADDR_W  data read address.
- `DATA_ROADDR`  out  ADDR_W  address of the returned data.
- `DATA_RVALID`  out  1  one-cycle pulse: read data valid.
- `DATA_RDATA`  out  DATA_W  read data.
- `DATA_WREN`  in  1  full-word write request.
- `DATA_WADDR`  in  ADDR_W  write address.
- `DATA_WDATA`  in  DATA_W  write data.
- `MEM_WAIT`  out  1  core stall.
- `MEM_REQ`  out  1  backend request.
- `MEM_WE`  out  1  backend write enable.
- `MEM_ADDR`  out  ADDR_W  backend address.
- `MEM_WDATA`  out  DATA_W  backend write data.
- `MEM_ACK`  in  1  backend completion; read data valid in the same cycle.
- `MEM_RDATA`  in  DATA_W  backend read data.

## Operation
- **Request slots.** There are three slots: I (inst read), D (data read) and W (write). Each holds a pending bit, an address and, for W only, write data.
- **Capture.** At a rising edge with `MEM_WAIT`=0, each asserted request (`INST_RDEN`, `DATA_RDEN`, `DATA_WREN`) loads its slot. While `MEM_WAIT`=1, all request inputs are ignored.
- **`MEM_WAIT`.** `MEM_WAIT` = OR of the three pending bits. It is decoded from registers only, with no combinational path from the inputs.
- **FSM states.**
  - IDLE: any slot pending → grant one slot and go to REQ.
  - REQ: stay in REQ until `MEM_ACK`. On ack, clear the granted slot. If another slot is still pending, grant it and stay in REQ (back-to-back). Otherwise go to IDLE.
- **Backend outputs.** On grant, register `MEM_ADDR`, `MEM_WE` and `MEM_WDATA` from the granted slot. `MEM_REQ` = (state==REQ). All backend outputs stay stable until ack.
- **Arbitration (default).** Fixed priority: W > D > I.
- **Read completion.** An ack on an I or D grant registers the matching `*_RVALID`=1 for one cycle, `*_ROADDR` = slot address, and `*_RDATA` = `MEM_RDATA`. `*_RDATA` and `*_ROADDR` hold their values until the next response on the same port.
- **Write completion.** An ack on a W grant clears the slot and produces no response pulse.
- **Flushed fetches.** The block has no flush input. The core discards stale fetches by comparing `INST_ROADDR`.
- `MEM_ACK` while in IDLE is ignored.

## Timing
- **Reset.** All outputs are 0, all slots are empty and the FSM is in IDLE. Reset asserted mid-transaction drops `MEM_REQ` immediately; a later ack belonging to the aborted transaction is ignored.
- **Single read, zero-wait memory:**
  - capture at edge E0;
  - `MEM_WAIT`=1 and grant in cycle 1;
  - `MEM_REQ`=1 in cycle 2, `MEM_ACK` in cycle 2;
  - `*_RVALID`=1 and `MEM_WAIT`=0 in cycle 3.
- **Back-to-back service.** Each further pending slot adds exactly one cycle per zero-wait ack. `MEM_REQ` remains high across consecutive grants.
- **Stall/response alignment.** `MEM_WAIT` falls in the same cycle as the last response's `RVALID`. The core's next requests are captured at the end of that cycle.
- **Response rate.** At most one `RVALID` pulse is produced per cycle across both ports.

## Configuration
- `MMU_RESP_ROUND_ROBIN_EN` defined: I and D rotate priority between them, using a last-granted pointer updated on each read ack. W is always granted first.
- Undefined: fixed priority W > D > I.

## Structure
- Package `mmu_resp_pkg` holds:
  - FSM state encoding (IDLE, REQ);
  - slot index constants (SLOT_I, SLOT_D, SLOT_W);
  - default widths.
- One sub-module, `mmu_resp_arb`: combinational grant selection from the pending bits plus the round-robin pointer register (present only under the macro).

## Test plan
- **Reset and single inst read.** Reset, then `INST_RDEN`=1, `INST_RIADDR`=0x100, memory returns 0x00000013 with zero wait → `INST_RVALID` in cycle 3, `INST_ROADDR`=0x100, `INST_RDATA`=0x13, `MEM_WAIT` high in cycles 1–2 only.
- **All three requests in one cycle.** W@0x200=0xDEADBEEF, D@0x200 and I@0x104 → backend order W, D, I. `DATA_RDATA`=0xDEADBEEF; `MEM_WAIT` high for 4 cycles.
- **Backend wait states.** Ack delayed 3 cycles → `MEM_ADDR`/`MEM_WE` stable throughout, `MEM_WAIT` held, `RVALID` exactly one cycle after ack.
- **Inputs ignored while stalled.** Change `INST_RIADDR` to 0x300 while `MEM_WAIT`=1 → ignored; the response carries the original address.
- **Reset mid-REQ.** Assert `RST`=0 during REQ, then pulse `MEM_ACK` → no `RVALID`, `MEM_REQ`=0, slots empty.
- **Round-robin (macro defined).** Repeated simultaneous I and D requests → grants alternate D, I, D, I. Without the macro, D always precedes I.
